// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
// Optional divide-by-zero trap enabled with `define DIV_ZERO_TRAP_EN.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             accept;

    // Trial subtract is WIDTH+1 bits wide plus a borrow bit on top.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    assign r_shift = {r_q, q_q[WIDTH-1]};
    assign trial   = {1'b0, r_shift} - {2'b00, dvsr_q};
    assign borrow  = trial[WIDTH+1];
    assign accept  = start && (state_q != StCalc);

`ifdef DIV_ZERO_TRAP_EN
    logic dz_q, dz_d;
    logic dz_out_q, dz_out_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvsr_d  = dvsr_q;
        q_d     = q_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        dz_d     = dz_q;
        dz_out_d = dz_out_q;
`endif
        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StCalc: begin
                if (borrow) begin
                    r_d = r_shift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                // Results are published on the edge that leaves DONE.
                done_d  = 1'b1;
                quot_d  = q_q;
                rem_d   = r_q;
                state_d = StIdle;
`ifdef DIV_ZERO_TRAP_EN
                dz_out_d = dz_q;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d = StCalc;
            dvsr_d  = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CntW'(WIDTH - 1);
`ifdef DIV_ZERO_TRAP_EN
            dz_d = 1'b0;
            if (state_q != StDone) begin
                dz_out_d = 1'b0;
            end
            if (divisor == '0) begin
                state_d = StDone;
                q_d     = '1;
                r_d     = dividend;
                dz_d    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvsr_q  <= '0;
            q_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvsr_q  <= dvsr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q     <= 1'b0;
            dz_out_q <= 1'b0;
        end else begin
            dz_q     <= dz_d;
            dz_out_q <= dz_out_d;
        end
    end

    assign div_by_zero = dz_out_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state_q == StCalc);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4): vector table, corner
// sequences, exhaustive and random operations against an arithmetic model.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference results derived from plain integer arithmetic.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input int b);
`ifdef DIV_ZERO_TRAP_EN
        return (b == 0) ? 1 : W + 1;
`else
        if (b == 0) return W + 1;
        return W + 1;
`endif
    endfunction

    function automatic int ref_busy(input int b);
`ifdef DIV_ZERO_TRAP_EN
        return (b == 0) ? 0 : W;
`else
        if (b == 0) return W;
        return W;
`endif
    endfunction

    function automatic int ref_dz(input int b);
`ifdef DIV_ZERO_TRAP_EN
        return (b == 0) ? 1 : 0;
`else
        if (b == 0) return 0;
        return 0;
`endif
    endfunction

    // lat = edges after the accepting edge until done is observed (-1 on timeout).
    task automatic do_op(input int a, input int b, output int lat, output int bcnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, held_ok, saw_done;

        vecs[0] = '{13, 3, 4, 1};
        vecs[1] = '{15, 15, 1, 0};
        vecs[2] = '{5, 11, 0, 5};
        vecs[3] = '{0, 7, 0, 0};
        vecs[4] = '{15, 1, 15, 0};
        vecs[5] = '{9, 0, 15, 9};
        vecs[6] = '{7, 2, 3, 1};

        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quot", int'(quotient), 0);
        chk("reset_rem", int'(remainder), 0);
        chk("reset_dz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors with latency, busy length and single-cycle done.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("vec%0d_quot", i), int'(quotient), vecs[i].q);
            chk($sformatf("vec%0d_rem", i), int'(remainder), vecs[i].r);
            chk($sformatf("vec%0d_lat", i), lat, ref_lat(vecs[i].b));
            chk($sformatf("vec%0d_busy", i), bcnt, ref_busy(vecs[i].b));
            chk($sformatf("vec%0d_dz", i), int'(div_by_zero), ref_dz(vecs[i].b));
            chk($sformatf("vec%0d_busy_at_done", i), int'(busy), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 1) begin
                start = 1'b1; dividend = 4'd9; divisor = 4'd2;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("busy_ignore_lat", lat, W + 1);
        chk("busy_ignore_quot", int'(quotient), 2);
        chk("busy_ignore_rem", int'(remainder), 2);
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        @(posedge clk);
        lat = -1;
        held_ok = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (quotient != 4'd2 || remainder != 4'd2) held_ok = 0;
        end
        chk("b2b_lat", lat, W + 1);
        chk("b2b_held", held_ok, 1);
        chk("b2b_quot", int'(quotient), 4);
        chk("b2b_rem", int'(remainder), 1);

        // Asynchronous reset mid-calculation.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy_before_rst", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_quot", int'(quotient), 0);
        chk("rst_rem", int'(remainder), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("rst_no_done", saw_done, 0);
        do_op(7, 2, lat, bcnt);
        chk("post_rst_quot", int'(quotient), 3);
        chk("post_rst_rem", int'(remainder), 1);
        chk("post_rst_lat", lat, W + 1);

        // Exhaustive nonzero-divisor sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_op(a, b, lat, bcnt);
                chk($sformatf("ex_%0d_%0d_quot", a, b), int'(quotient), ref_q(a, b));
                chk($sformatf("ex_%0d_%0d_rem", a, b), int'(remainder), ref_r(a, b));
                chk($sformatf("ex_%0d_%0d_lat", a, b), lat, ref_lat(b));
            end
        end

        // Random operations, divisor zero included.
        for (int i = 0; i < 60; i++) begin
            int a, b;
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            do_op(a, b, lat, bcnt);
            chk($sformatf("rnd%0d_quot", i), int'(quotient), ref_q(a, b));
            chk($sformatf("rnd%0d_rem", i), int'(remainder), ref_r(a, b));
            chk($sformatf("rnd%0d_dz", i), int'(div_by_zero), ref_dz(b));
            chk($sformatf("rnd%0d_lat", i), lat, ref_lat(b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
